// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
//   Shares one single-port synchronous frame-buffer RAM between VGA scan-out and an
//   MCU-side pixel writer. The framebuffer is downscaled by 2^PIX_SHIFT in each axis.
//   Display fetches always win; the writer takes every RAM cycle that is not a fetch.
//
// Optional feature (compile-time macro FB_DOUBLE_BUF_EN):
//   defined   - two banks, writer targets the hidden bank, swap_req swaps at vblank entry.
//   undefined - one bank, bank bit tied 0, swap_req ignored, swap_done tied 0.
//
// Ports:
//   i_clk, i_reset_n      clock, asynchronous active-low reset
//   i_hcount/i_vcount     raster position from vga_controller
//   i_active_video        visible-area flag from vga_controller
//   i_wr_valid/addr/data  writer request; o_wr_ready marks a free RAM slot this cycle
//   i_swap_req            one-cycle swap request; o_swap_done pulses when it executes
//   o_mem_en/we/addr/wdata, i_mem_rdata   single-port RAM interface (addr MSB = bank)
//   o_pixel_data/active   display pixel and its qualifier, 2 cycles after the raster inputs
//   o_frame_start         pulse at hcount==0 && vcount==0
//   o_wr_err              sticky: an out-of-range write was dropped
module vga_fb_arbiter #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned PIX_SHIFT = 2,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 15
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [10:0]       i_hcount,
  input  logic [9:0]        i_vcount,
  input  logic              i_active_video,
  input  logic              i_wr_valid,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ready,
  input  logic              i_swap_req,
  output logic              o_swap_done,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W:0]   o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [DATA_W-1:0] o_pixel_data,
  output logic              o_pixel_active,
  output logic              o_frame_start,
  output logic              o_wr_err
);

  localparam int unsigned H_FB     = H_ACTIVE >> PIX_SHIFT;
  localparam int unsigned FB_DEPTH = H_FB * (V_ACTIVE >> PIX_SHIFT);

  typedef enum logic [0:0] {StScan, StVblank} frame_state_e;

  frame_state_e r_state, w_state_next;

  logic              r_line_ok;   // a full line start has been seen since reset
  logic              r_fetch_d1;
  logic              r_act_d1;
  logic              r_act_d2;
  logic [DATA_W-1:0] r_pix;
  logic              r_wr_err;

  logic              w_line_start;
  logic              w_origin;
  logic              w_vblank_edge;
  logic              w_fetch;
  logic [ADDR_W-1:0] w_fetch_addr;
  logic              w_wr_xfer;
  logic              w_wr_in_range;
  logic              w_wr_mem;
  logic              w_wr_bad;
  logic              w_disp_bank;
  logic              w_wr_bank;

  assign w_line_start  = (i_hcount == 11'd0);
  assign w_origin      = w_line_start && (i_vcount == 10'd0);
  assign w_vblank_edge = w_line_start && (i_vcount == 10'(V_ACTIVE));

  // After a reset release the partial line is skipped: fetching resumes at the next
  // line start so the pixel pipeline never restarts mid-line.
  assign w_fetch = i_reset_n && i_active_video && (i_hcount[PIX_SHIFT-1:0] == '0) &&
                   (r_line_ok || w_line_start);

  assign w_fetch_addr = ADDR_W'((32'(i_vcount) >> PIX_SHIFT) * H_FB +
                                (32'(i_hcount) >> PIX_SHIFT));

  // Ready depends only on the raster position, never on i_wr_valid.
  assign w_wr_xfer     = i_reset_n && i_wr_valid && !w_fetch;
  assign w_wr_in_range = (32'(i_wr_addr) < FB_DEPTH);
  assign w_wr_mem      = w_wr_xfer && w_wr_in_range;
  assign w_wr_bad      = w_wr_xfer && !w_wr_in_range;

`ifdef FB_DOUBLE_BUF_EN
  logic r_disp_bank;
  logic r_swap_pend;
  logic w_swap_exec;

  // A request arriving on the vblank-entry cycle itself is honoured immediately.
  assign w_swap_exec = i_reset_n && (r_state == StScan) && w_vblank_edge &&
                       (r_swap_pend || i_swap_req);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_disp_bank <= 1'b0;
      r_swap_pend <= 1'b0;
    end else begin
      r_disp_bank <= r_disp_bank ^ w_swap_exec;
      r_swap_pend <= (r_swap_pend || i_swap_req) && !w_swap_exec;
    end
  end

  assign w_disp_bank = r_disp_bank;
  assign w_wr_bank   = !r_disp_bank;
  assign o_swap_done = w_swap_exec;
`else
  logic w_unused_swap_req;

  assign w_unused_swap_req = i_swap_req;
  assign w_disp_bank       = 1'b0;
  assign w_wr_bank         = 1'b0;
  assign o_swap_done       = 1'b0;
`endif

  // Frame FSM: only marks the swap point; fetch decisions use the live raster inputs.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StScan:   if (w_vblank_edge) w_state_next = StVblank;
      StVblank: if (w_origin)      w_state_next = StScan;
      default:  w_state_next = StScan;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= StScan;
      r_line_ok  <= 1'b0;
      r_fetch_d1 <= 1'b0;
      r_act_d1   <= 1'b0;
      r_act_d2   <= 1'b0;
      r_pix      <= '0;
      r_wr_err   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_line_ok  <= r_line_ok || w_line_start;
      r_fetch_d1 <= w_fetch;
      r_act_d1   <= i_active_video;
      r_act_d2   <= r_act_d1;
      r_wr_err   <= r_wr_err || w_wr_bad;
      // RAM data is valid the cycle after the fetch; hold it until the next one lands.
      if (r_fetch_d1) begin
        r_pix <= i_mem_rdata;
      end
    end
  end

  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (w_fetch) begin
      o_mem_en   = 1'b1;
      o_mem_addr = {w_disp_bank, w_fetch_addr};
    end else if (w_wr_mem) begin
      o_mem_en    = 1'b1;
      o_mem_we    = 1'b1;
      o_mem_addr  = {w_wr_bank, i_wr_addr};
      o_mem_wdata = i_wr_data;
    end
  end

  assign o_wr_ready     = i_reset_n && !w_fetch;
  assign o_pixel_active = r_act_d2;
  assign o_pixel_data   = r_act_d2 ? r_pix : '0;
  assign o_frame_start  = i_reset_n && w_origin;
  assign o_wr_err       = r_wr_err;

endmodule
